// File: rtl/sram_master.sv
// Asynchronous-style SRAM bus master: one read or write per request, with
// programmable address setup, strobe width and hold, all outputs registered.
module sram_master #(
  parameter int unsigned TSET = 3,
  parameter int unsigned NWS  = 3,
  parameter int unsigned THLD = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        wr,
  input  logic [9:0]  req_addr,
  input  logic [15:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [15:0] rdata,
  output logic [9:0]  addr,
  output logic        ncs,
  output logic        nwe,
  output logic        noe,
  inout  wire  [15:0] sram_data
);

  localparam int unsigned AW = 10;
  localparam int unsigned DW = 16;
  localparam int unsigned CW = 8;

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          wr_q;
  logic [DW-1:0] wdata_q;
  logic          drive_q;
  logic          accept_c;
  logic          last_c;
  logic          finish_c;

  // Write data goes on the bus only during the strobe and hold of a write.
  assign sram_data = drive_q ? wdata_q : {DW{1'bz}};

  // Next-state logic; the shared phase counter reloads on every state change.
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    accept_c = 1'b0;
    last_c   = (cnt == '0);
    finish_c = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          state_n  = SETUP;
          cnt_n    = CW'(TSET - 1);
          accept_c = 1'b1;
        end
      end
      SETUP: begin
        if (last_c) begin
          state_n = STROBE;
          cnt_n   = CW'(NWS - 1);
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      STROBE: begin
        if (last_c) begin
          state_n = HOLD;
          cnt_n   = CW'(THLD - 1);
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      HOLD: begin
        if (last_c) begin
          state_n  = IDLE;
          cnt_n    = '0;
          finish_c = 1'b1;
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  // State, request latches and registered bus outputs decoded from the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
      addr    <= '0;
      ncs     <= 1'b1;
      nwe     <= 1'b1;
      noe     <= 1'b1;
      drive_q <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      rdata   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (accept_c) begin
        wr_q    <= wr;
        wdata_q <= wdata;
        addr    <= AW'(req_addr);
      end
      ncs     <= (state_n == IDLE);
      nwe     <= !((state_n == STROBE) && wr_q);
      noe     <= !((state_n == STROBE) && !wr_q);
      drive_q <= wr_q && ((state_n == STROBE) || (state_n == HOLD));
      done    <= finish_c;
      busy    <= (state_n != IDLE) || finish_c;
      // Sample read data on the edge that closes the strobe, while noe is still low.
      if ((state == STROBE) && last_c && !wr_q) begin
        rdata <= sram_data;
      end
    end
  end

endmodule
